// File: rtl/peecc_pkg.sv
// rtl/peecc_pkg.sv - shared sizing helpers, LFSR taps, FSM states and pipeline latency for the PEECC loopback
package peecc_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Smallest p with 2^p >= data_w + p + 1.
  function automatic int calc_p(input int data_w);
    int p;
    p = 1;
    for (int i = 0; i < 8; i++)
      if ((1 << p) < data_w + p + 1) p = p + 1;
    return p;
  endfunction

  function automatic int code_w(input int data_w);
    return data_w + calc_p(data_w) + 1;
  endfunction

  function automatic bit is_data_pos(input int pos);
    return (pos > 2) && ((pos & (pos - 1)) != 0);
  endfunction

  // Payload bit index held at a non-power-of-two position: pos - 1 - ceil(log2(pos)).
  function automatic int data_idx(input int pos);
    return pos - 1 - $clog2(pos);
  endfunction

endpackage

// File: rtl/peecc_secded_dec.sv
// rtl/peecc_secded_dec.sv - combinational SEC-DED syndrome, single-bit correction and error flags
module peecc_secded_dec import peecc_pkg::*; #(
  parameter int DATA_W = 16,
  localparam int P = calc_p(DATA_W),
  localparam int CODE_W = code_w(DATA_W)
) (
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] corrected,
  output logic              err_single,
  output logic              err_double
);

  logic [P-1:0] syn;
  logic         overall;

  always_comb begin
    syn = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (code[pos]) syn = syn ^ P'(pos);
  end

  assign overall = ^code;

  always_comb begin
    corrected  = code;
    err_single = 1'b0;
    err_double = 1'b0;
    if (overall) begin
      if (syn == '0) begin
        corrected[0] = ~code[0];
        err_single   = 1'b1;
      end else if (int'(syn) < CODE_W) begin
        for (int pos = 1; pos < CODE_W; pos++)
          if (syn == P'(pos)) corrected[pos] = ~code[pos];
        err_single = 1'b1;
      end else begin
        // Syndrome points past the codeword: more than one bit is wrong.
        err_double = 1'b1;
      end
    end else if (syn != '0) begin
      err_double = 1'b1;
    end
  end

endmodule

// File: rtl/peecc_ecc_loopback.sv
// rtl/peecc_ecc_loopback.sv - LFSR -> SEC-DED encode -> error channel -> decode -> compare loopback
// Optional PEECC_STATS_EN adds saturating corr_cnt/uncorr_cnt outputs.
module peecc_ecc_loopback import peecc_pkg::*; #(
  parameter int          DATA_W    = 16,
  parameter int          NUM_WORDS = 11,
  parameter logic [31:0] SEED      = 32'hACE10001,
  parameter int          CNT_W     = 16,
  localparam int         P         = calc_p(DATA_W),
  localparam int         CODE_W    = code_w(DATA_W)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ValidIn,
  input  logic [CODE_W-1:0]           inj_mask,
  output logic [NUM_WORDS*CODE_W-1:0] registers,
  output logic                        IsEqual,
  output logic                        ValidOut,
  output logic                        err_single,
  output logic                        err_double,
  output logic [CNT_W-1:0]            mismatch_cnt,
`ifdef PEECC_STATS_EN
  output logic [CNT_W-1:0]            corr_cnt,
  output logic [CNT_W-1:0]            uncorr_cnt,
`endif
  output logic                        done
);

  state_t                      state, state_nx;
  logic [CNT_W-1:0]            word_cnt;
  logic [1:0]                  drain_cnt;
  logic                        issue;
  logic                        last_word;
  logic [31:0]                 lfsr;
  logic [DATA_W-1:0]           src_word;

  logic [CODE_W-1:0]           placed;
  logic [P-1:0]                enc_syn;
  logic [CODE_W-1:0]           enc_code;

  logic                        s1_valid, s2_valid, s3_valid;
  logic [CODE_W-1:0]           s1_code, s1_mask;
  logic [CODE_W-1:0]           s2_code, s2_clean;
  logic [CODE_W-1:0]           s3_code, s3_clean;
  logic                        s3_single, s3_double;

  logic [CODE_W-1:0]           dec_corrected;
  logic                        dec_single, dec_double;

  logic [NUM_WORDS*CODE_W-1:0] bank;
  logic                        is_equal;
  logic [CNT_W-1:0]            mism;

  assign src_word  = lfsr[DATA_W-1:0];
  assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE, RUN: begin
        if (ValidIn) begin
          issue    = 1'b1;
          state_nx = last_word ? DRAIN : RUN;
        end
      end
      DRAIN: if (drain_cnt == 2'(PIPE_LAT - 1)) state_nx = DONE;
      DONE:  done = 1'b1;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      word_cnt  <= '0;
      drain_cnt <= '0;
      lfsr      <= SEED;
    end else begin
      if (issue) begin
        word_cnt <= word_cnt + CNT_W'(1);
        lfsr     <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
      else                drain_cnt <= '0;
    end
  end

  for (genvar g = 0; g < CODE_W; g++) begin : g_place
    if (is_data_pos(g)) begin : g_data
      assign placed[g] = src_word[data_idx(g)];
    end else begin : g_zero
      assign placed[g] = 1'b0;
    end
  end

  // Parity bits are the syndrome of the data-only word, so the full codeword's syndrome is zero.
  always_comb begin
    enc_syn = '0;
    for (int pos = 1; pos < CODE_W; pos++)
      if (placed[pos]) enc_syn = enc_syn ^ P'(pos);
  end

  always_comb begin
    enc_code = placed;
    for (int k = 0; k < P; k++) enc_code[1 << k] = enc_syn[k];
    enc_code[0] = (^placed) ^ (^enc_syn);
  end

  peecc_secded_dec #(.DATA_W(DATA_W)) u_dec (
    .code       (s2_code),
    .corrected  (dec_corrected),
    .err_single (dec_single),
    .err_double (dec_double)
  );

  // The mask travels with its word from issue; the clean codeword rides along as the compare reference.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_code   <= '0;
      s1_mask   <= '0;
      s2_code   <= '0;
      s2_clean  <= '0;
      s3_code   <= '0;
      s3_clean  <= '0;
      s3_single <= 1'b0;
      s3_double <= 1'b0;
    end else begin
      s1_valid  <= issue;
      s1_code   <= enc_code;
      s1_mask   <= inj_mask;
      s2_valid  <= s1_valid;
      s2_code   <= s1_code ^ s1_mask;
      s2_clean  <= s1_code;
      s3_valid  <= s2_valid;
      s3_code   <= dec_corrected;
      s3_clean  <= s2_clean;
      s3_single <= dec_single;
      s3_double <= dec_double;
    end
  end

  if (NUM_WORDS > 1) begin : g_bank
    always_ff @(posedge CLK) begin
      if (RST)           bank <= '0;
      else if (s3_valid) bank <= {bank[(NUM_WORDS-1)*CODE_W-1:0], s3_code};
    end
  end else begin : g_bank_one
    always_ff @(posedge CLK) begin
      if (RST)           bank <= '0;
      else if (s3_valid) bank <= s3_code;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      is_equal <= 1'b1;
      mism     <= '0;
    end else if (s3_valid && (s3_code != s3_clean)) begin
      is_equal <= 1'b0;
      if (mism != '1) mism <= mism + CNT_W'(1);
    end
  end

`ifdef PEECC_STATS_EN
  logic [CNT_W-1:0] corr_q, uncorr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else if (s3_valid) begin
      if (s3_single && corr_q != '1)   corr_q   <= corr_q + CNT_W'(1);
      if (s3_double && uncorr_q != '1) uncorr_q <= uncorr_q + CNT_W'(1);
    end
  end

  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
`endif

  assign registers    = bank;
  assign IsEqual      = is_equal;
  assign mismatch_cnt = mism;
  assign ValidOut     = s3_valid;
  assign err_single   = s3_valid & s3_single;
  assign err_double   = s3_valid & s3_double;

endmodule
